// File: rtl/i2c_write_master_if.sv
// Request/data/bus bundle between the ADC config sequencer and the I2C write master.
// The master modport is the I2C engine; the slave modport is whoever drives it.
interface i2c_write_master_if #(
  parameter int MAXB = 16
) ();
  localparam int LEN_W = $clog2(MAXB + 1);

  logic             start;
  logic [6:0]       addr;
  logic [LEN_W-1:0] nbytes;
  logic [7:0]       wdata;
  logic             wdata_valid;
  logic             wdata_ready;
  logic             busy;
  logic             done;
  logic             nack;
  logic             scl_oe;
  logic             sda_oe;
  logic             sda_in;

  modport master (
    input  start, addr, nbytes, wdata, wdata_valid, sda_in,
    output wdata_ready, busy, done, nack, scl_oe, sda_oe
  );

  modport slave (
    output start, addr, nbytes, wdata, wdata_valid, sda_in,
    input  wdata_ready, busy, done, nack, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_write_master.sv
// I2C master for multi-byte writes: START, addr+W, N bytes, STOP, NACK abort.
// Open-drain pins are registered and updated on quarter-bit boundaries.
module i2c_write_master #(
  parameter int DIV_Q = 4,
  parameter int MAXB  = 16
) (
  input  logic                clk,
  input  logic                reset,
  i2c_write_master_if.master  bus
);
  localparam int LEN_W = $clog2(MAXB + 1);
  localparam int CW    = (DIV_Q > 1) ? $clog2(DIV_Q) : 1;
  localparam logic [CW-1:0]    CLAST = CW'(DIV_Q - 1);
  localparam logic [LEN_W-1:0] LMAX  = LEN_W'(MAXB);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, WAIT, DATA, ACK_D, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cyc;
  logic [1:0]       q;
  logic [2:0]       bitcnt;
  logic [7:0]       sh;
  logic [6:0]       addr_q;
  logic [LEN_W-1:0] rem;
  logic [7:0]       hbuf;
  logic             held;
  logic [7:0]       nb;
  logic             qend;
  logic             take;

  assign qend = (cyc == CLAST);
  assign take = bus.wdata_valid & bus.wdata_ready;
  assign nb   = held ? hbuf : bus.wdata;

  // Line levels {scl_oe, sda_oe} for quarter qn of a bit in state st.
  function automatic logic [1:0] drv(state_t st, logic [1:0] qn, logic sbit);
    case (st)
      START:        drv = {qn == 2'd3, qn[1]};
      ADDR, DATA:   drv = {~qn[1], ~sbit};
      ACK_A, ACK_D: drv = {~qn[1], 1'b0};
      WAIT:         drv = 2'b10;
      STOP:         drv = {qn == 2'd0, ~qn[1]};
      default:      drv = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cyc             <= '0;
      q               <= '0;
      bitcnt          <= '0;
      sh              <= '0;
      addr_q          <= '0;
      rem             <= '0;
      hbuf            <= '0;
      held            <= 1'b0;
      bus.scl_oe      <= 1'b0;
      bus.sda_oe      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.nack        <= 1'b0;
      bus.wdata_ready <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (take) begin
        hbuf            <= bus.wdata;
        held            <= 1'b1;
        bus.wdata_ready <= 1'b0;
      end
      if (state != IDLE && state != WAIT)
        cyc <= qend ? '0 : cyc + 1'b1;

      case (state)
        IDLE: if (bus.start) begin
          state    <= START;
          bus.busy <= 1'b1;
          bus.nack <= 1'b0;
          addr_q   <= bus.addr;
          rem      <= (bus.nbytes > LMAX) ? LMAX : bus.nbytes;
          q        <= '0;
          cyc      <= '0;
        end
        // Master clock stretch: SCL stays low until the source delivers a byte.
        WAIT: if (take) begin
          state                  <= DATA;
          sh                     <= nb;
          held                   <= 1'b0;
          rem                    <= rem - 1'b1;
          bitcnt                 <= '0;
          q                      <= '0;
          cyc                    <= '0;
          {bus.scl_oe, bus.sda_oe} <= drv(DATA, 2'd0, nb[7]);
        end
        default: if (qend) begin
          if (q != 2'd3) begin
            q <= q + 2'd1;
            {bus.scl_oe, bus.sda_oe} <= drv(state, q + 2'd1, sh[7]);
            // Last cycle of Q2 in an ACK bit: sample the slave's answer.
            if (q == 2'd2 && (state == ACK_A || state == ACK_D)) begin
              if (bus.sda_in)
                bus.nack <= 1'b1;
              else if (rem != '0 && !held)
                bus.wdata_ready <= 1'b1;
            end
          end else begin
            q <= 2'd0;
            case (state)
              START: begin
                state  <= ADDR;
                sh     <= {addr_q, 1'b0};
                bitcnt <= '0;
                {bus.scl_oe, bus.sda_oe} <= drv(ADDR, 2'd0, addr_q[6]);
              end
              ADDR, DATA: begin
                if (bitcnt == 3'd7) begin
                  state <= (state == ADDR) ? ACK_A : ACK_D;
                  {bus.scl_oe, bus.sda_oe} <= drv(ACK_A, 2'd0, 1'b0);
                end else begin
                  bitcnt <= bitcnt + 3'd1;
                  sh     <= {sh[6:0], 1'b0};
                  {bus.scl_oe, bus.sda_oe} <= drv(state, 2'd0, sh[6]);
                end
              end
              ACK_A, ACK_D: begin
                if (bus.nack || rem == '0) begin
                  state <= STOP;
                  {bus.scl_oe, bus.sda_oe} <= drv(STOP, 2'd0, 1'b0);
                end else if (held || take) begin
                  state  <= DATA;
                  sh     <= nb;
                  held   <= 1'b0;
                  rem    <= rem - 1'b1;
                  bitcnt <= '0;
                  {bus.scl_oe, bus.sda_oe} <= drv(DATA, 2'd0, nb[7]);
                end else begin
                  state <= WAIT;
                  {bus.scl_oe, bus.sda_oe} <= drv(WAIT, 2'd0, 1'b0);
                end
              end
              STOP: begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                {bus.scl_oe, bus.sda_oe} <= 2'b00;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master: slave/monitor model decodes SDA bytes into a
// queue that is scoreboarded against bytes pushed when each transaction is set up.
module tb_i2c_write_master;
  localparam int DIV_Q = 1;
  localparam int MAXB  = 16;
  localparam int LEN_W = $clog2(MAXB + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_write_master_if #(.MAXB(MAXB)) bus ();
  i2c_write_master #(.DIV_Q(DIV_Q), .MAXB(MAXB)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- slave / bus monitor ----------------
  logic       slave_low = 1'b0;
  int         bitpos = 0, byteidx = 0, ack_bad = 0;
  int         nack_idx = -1;
  bit         in_txn = 1'b0, pscl = 1'b1, psda = 1'b1;
  logic [7:0] shreg = 8'h00;
  logic [7:0] obs_q[$];
  logic       scl_l, sda_l;

  assign bus.sda_in = ~bus.sda_oe & ~slave_low;
  assign scl_l = ~bus.scl_oe;
  assign sda_l = bus.sda_in;

  always @(negedge clk) begin
    if (reset) begin
      in_txn = 1'b0; slave_low = 1'b0; bitpos = 0; byteidx = 0;
    end else if (pscl && scl_l && psda && !sda_l) begin
      in_txn = 1'b1; bitpos = 0; byteidx = 0; slave_low = 1'b0;
    end else if (pscl && scl_l && !psda && sda_l) begin
      in_txn = 1'b0; slave_low = 1'b0;
    end else if (in_txn && !pscl && scl_l) begin
      if (bitpos < 8) shreg = {shreg[6:0], sda_l};
      else if (bus.sda_oe !== 1'b0) ack_bad++;
      bitpos++;
      if (bitpos == 8) obs_q.push_back(shreg);
      if (bitpos == 9) begin bitpos = 0; byteidx++; end
    end else if (in_txn && pscl && !scl_l) begin
      slave_low = (bitpos == 8) && (byteidx != nack_idx);
    end
    pscl = scl_l;
    psda = sda_l;
  end

  // ---------------- byte source ----------------
  logic [7:0] src_q[$];
  int         src_base = 0, hs_cnt = 0, rdy_cnt = 0, drv_idx;
  bit         src_en = 1'b1;

  always @(posedge clk) begin
    if (bus.wdata_valid === 1'b1 && bus.wdata_ready === 1'b1) hs_cnt++;
    if (bus.wdata_ready === 1'b1) rdy_cnt++;
  end

  always @(negedge clk) begin
    drv_idx = hs_cnt - src_base;
    bus.wdata_valid = src_en && (drv_idx < src_q.size());
    bus.wdata = (drv_idx < src_q.size()) ? src_q[drv_idx] : 8'h00;
  end

  // ---------------- checking helpers ----------------
  logic [7:0] exp_q[$];
  int         obs_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_nbytes"}, obs_q.size() - obs_rd, exp_q.size());
    for (int i = 0; i < exp_q.size() && obs_rd < obs_q.size(); i++) begin
      chk({tag, "_byte"}, obs_q[obs_rd], exp_q[i]);
      obs_rd++;
    end
    obs_rd = obs_q.size();
    exp_q.delete();
    chk({tag, "_ack_release"}, ack_bad, 0);
  endtask

  task automatic setup(input logic [6:0] a, input int nsrc, input int nexp);
    logic [7:0] b;
    src_q.delete();
    src_base = hs_cnt;
    exp_q.push_back({a, 1'b0});
    for (int i = 0; i < nsrc; i++) begin
      b = 8'($urandom_range(0, 255));
      src_q.push_back(b);
      if (i < nexp) exp_q.push_back(b);
    end
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4000) begin @(negedge clk); cyc++; end
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_busy_low_at_done"}, bus.busy, 1'b0);
  endtask

  task automatic go(input string tag, input logic [6:0] a, input int n, output int cyc);
    bus.addr = a; bus.nbytes = LEN_W'(n); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1'b1);
    wait_done(tag, cyc);
  endtask

  int cyc, h0, r0, k;

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.addr = '0; bus.nbytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", bus.scl_oe, 1'b0);
    chk("rst_sda_oe", bus.sda_oe, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_nack", bus.nack, 1'b0);
    chk("rst_ready", bus.wdata_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // T1: two bytes, all ACKed, exact length 29 bits * 4 quarters
    src_q.delete(); src_base = hs_cnt;
    src_q.push_back(8'hA5); src_q.push_back(8'h3C);
    exp_q.push_back(8'h90); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    h0 = hs_cnt;
    go("t1", 7'h48, 2, cyc);
    chk("t1_len", cyc, 29 * 4 * DIV_Q);
    chk("t1_nack", bus.nack, 1'b0);
    chk("t1_hs", hs_cnt - h0, 2);
    sb_check("t1");
    @(negedge clk);
    chk("t1_done_pulse", bus.done, 1'b0);

    // T2: address NACK, no byte fetch
    nack_idx = 0;
    setup(7'h3F, 1, 0);
    h0 = hs_cnt; r0 = rdy_cnt;
    go("t2", 7'h3F, 1, cyc);
    chk("t2_nack", bus.nack, 1'b1);
    chk("t2_ready_never", rdy_cnt - r0, 0);
    chk("t2_hs", hs_cnt - h0, 0);
    chk("t2_len", cyc, 11 * 4 * DIV_Q);
    sb_check("t2");
    @(negedge clk);
    chk("t2_nack_hold", bus.nack, 1'b1);

    // T3: NACK on first of three data bytes
    nack_idx = 1;
    setup(7'h55, 3, 1);
    h0 = hs_cnt;
    go("t3", 7'h55, 3, cyc);
    chk("t3_nack", bus.nack, 1'b1);
    chk("t3_hs", hs_cnt - h0, 1);
    chk("t3_len", cyc, 20 * 4 * DIV_Q);
    sb_check("t3");
    nack_idx = -1;
    @(negedge clk);

    // T5a: address probe, then back-to-back start in the done cycle with clamped count
    setup(7'h10, 1, 0);
    h0 = hs_cnt;
    go("t5a", 7'h10, 0, cyc);
    chk("t5a_nack", bus.nack, 1'b0);
    chk("t5a_hs", hs_cnt - h0, 0);
    chk("t5a_len", cyc, 11 * 4 * DIV_Q);
    sb_check("t5a");
    setup(7'h7F, MAXB + 4, MAXB);
    h0 = hs_cnt;
    go("t5b", 7'h7F, MAXB + 5, cyc);
    chk("t5b_nack", bus.nack, 1'b0);
    chk("t5b_hs", hs_cnt - h0, MAXB);
    chk("t5b_len", cyc, (2 + 9 * (1 + MAXB)) * 4 * DIV_Q);
    sb_check("t5b");
    @(negedge clk);

    // T4: source withholds data after ACK_A; SCL stretched low, SDA released
    src_en = 1'b0;
    setup(7'h1B, 2, 2);
    h0 = hs_cnt;
    bus.addr = 7'h1B; bus.nbytes = LEN_W'(2); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (bus.wdata_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    chk("t4_ready", bus.wdata_ready, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_scl_held", bus.scl_oe, 1'b1);
      chk("t4_sda_stable", bus.sda_oe, 1'b0);
    end
    chk("t4_no_hs", hs_cnt - h0, 0);
    src_en = 1'b1;
    wait_done("t4", cyc);
    chk("t4_nack", bus.nack, 1'b0);
    chk("t4_hs", hs_cnt - h0, 2);
    sb_check("t4");
    @(negedge clk);

    // T6: reset in the middle of the data byte, then a fresh transaction
    setup(7'h22, 1, 1);
    bus.addr = 7'h22; bus.nbytes = LEN_W'(1); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!(byteidx == 1 && bitpos == 3) && k < 1000) begin @(negedge clk); k++; end
    chk("t6_reached_data", (byteidx == 1 && bitpos == 3), 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_scl_rel", bus.scl_oe, 1'b0);
    chk("t6_sda_rel", bus.sda_oe, 1'b0);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_done", bus.done, 1'b0);
    chk("t6_ready", bus.wdata_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    obs_rd = obs_q.size();
    setup(7'h2A, 1, 1);
    h0 = hs_cnt;
    go("t6b", 7'h2A, 1, cyc);
    chk("t6b_len", cyc, 20 * 4 * DIV_Q);
    chk("t6b_nack", bus.nack, 1'b0);
    chk("t6b_hs", hs_cnt - h0, 1);
    sb_check("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
